striping_nlane: RTL and testbench

Parametrised successor to the two-lane striping block. Accepts a stream of words on `data_in`/`valid_in` at the `clk_2f` rate and assembles them round-robin into stripes of `NUM_LANES` words. Each complete stripe is presented on all lanes simultaneously with a one-cycle per-lane valid. An optional idle timer flushes partial stripes. Sits between the serial source (probador or upstream byte-unstriping logic) and the per-lane serializers.

---
 rtl/striping_pkg.sv | 14 +
 rtl/striping_nlane_if.sv | 25 ++
 rtl/striping_idle_timer.sv | 26 ++
 rtl/striping_nlane.sv | 98 +++++++++
 tb/tb_striping_nlane.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/striping_pkg.sv
// rtl/striping_pkg.sv - shared constants, state encoding and pointer-width helper for the striping block
package striping_pkg;

    localparam int STRIPING_DATA_WIDTH = 32;
    localparam int STRIPING_NUM_LANES  = 4;

    localparam logic [0:0] STRIPE_EMPTY   = 1'b0;
    localparam logic [0:0] STRIPE_FILLING = 1'b1;

    function automatic int ptr_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/striping_nlane_if.sv
// rtl/striping_nlane_if.sv - serial word input and striped lane output bundle
interface striping_nlane_if
    import striping_pkg::*;
#(
    parameter int DATA_WIDTH = STRIPING_DATA_WIDTH,
    parameter int NUM_LANES  = STRIPING_NUM_LANES
);
    logic                            valid_in;
    logic [DATA_WIDTH-1:0]           data_in;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data;
    logic [NUM_LANES-1:0]            lane_valid;
    logic                            stripe_partial;
    logic [ptr_width(NUM_LANES)-1:0] lane_ptr;

    modport master (
        output valid_in, data_in,
        input  lane_data, lane_valid, stripe_partial, lane_ptr
    );

    modport slave (
        input  valid_in, data_in,
        output lane_data, lane_valid, stripe_partial, lane_ptr
    );

endinterface

// File: rtl/striping_idle_timer.sv
// rtl/striping_idle_timer.sv - saturating idle-cycle counter that signals a partial-stripe flush
module striping_idle_timer #(
    parameter int IDLE_GAP = 2
) (
    input  logic clk_2f,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic expired
);
    localparam logic [7:0] GAP = 8'(IDLE_GAP);

    logic [7:0] idle_cnt;

    // Fires on the idle cycle that would bring the count to IDLE_GAP.
    assign expired = count_en && (idle_cnt == GAP - 8'd1);

    always_ff @(posedge clk_2f) begin
        if (reset || clear || expired) begin
            idle_cnt <= '0;
        end else if (count_en && idle_cnt != GAP) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/striping_nlane.sv
// rtl/striping_nlane.sv - round-robin word-to-stripe assembler; idle flush under STRIPING_IDLE_FLUSH_EN
module striping_nlane
    import striping_pkg::*;
#(
    parameter int DATA_WIDTH = STRIPING_DATA_WIDTH,
    parameter int NUM_LANES  = STRIPING_NUM_LANES,
    parameter int IDLE_GAP   = 2
) (
    input  logic             clk_2f,
    input  logic             reset,
    striping_nlane_if.slave  bus
);
    localparam int               PTR_W     = ptr_width(NUM_LANES);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);

    if (NUM_LANES < 2 || NUM_LANES > 16 || (NUM_LANES & (NUM_LANES - 1)) != 0) begin : g_bad_lanes
        $error("striping_nlane: NUM_LANES must be a power of two in 2..16");
    end
    if (IDLE_GAP < 1 || IDLE_GAP > 255) begin : g_bad_gap
        $error("striping_nlane: IDLE_GAP must be in 1..255");
    end

    logic [0:0]                      state;
    logic [PTR_W-1:0]                ptr;
    logic [NUM_LANES-1:0]            fill_mask;
    logic [DATA_WIDTH-1:0]           stripe_buf [NUM_LANES];
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_q;
    logic [NUM_LANES-1:0]            lane_valid_q;
    logic                            partial_q;
    logic                            flush;

`ifdef STRIPING_IDLE_FLUSH_EN
    logic idle_expired;

    striping_idle_timer #(
        .IDLE_GAP (IDLE_GAP)
    ) u_idle_timer (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .count_en (!bus.valid_in && state == STRIPE_FILLING),
        .clear    (bus.valid_in),
        .expired  (idle_expired)
    );

    assign flush = idle_expired;
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state        <= STRIPE_EMPTY;
            ptr          <= '0;
            fill_mask    <= '0;
            lane_data_q  <= '0;
            lane_valid_q <= '0;
            partial_q    <= 1'b0;
        end else begin
            lane_valid_q <= '0;
            partial_q    <= 1'b0;
            if (bus.valid_in) begin
                if (ptr == LAST_LANE) begin
                    // The final word bypasses the buffer straight into its lane.
                    for (int i = 0; i < NUM_LANES; i++) begin
                        lane_data_q[i*DATA_WIDTH +: DATA_WIDTH] <=
                            (i == NUM_LANES - 1) ? bus.data_in : stripe_buf[i];
                    end
                    lane_valid_q <= '1;
                    fill_mask    <= '0;
                    ptr          <= '0;
                    state        <= STRIPE_EMPTY;
                end else begin
                    stripe_buf[ptr] <= bus.data_in;
                    fill_mask       <= ((state == STRIPE_EMPTY) ? '0 : fill_mask)
                                       | (NUM_LANES'(1) << ptr);
                    ptr             <= ptr + PTR_W'(1);
                    state           <= STRIPE_FILLING;
                end
            end else if (flush) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    lane_data_q[i*DATA_WIDTH +: DATA_WIDTH] <=
                        fill_mask[i] ? stripe_buf[i] : '0;
                end
                lane_valid_q <= fill_mask;
                partial_q    <= 1'b1;
                fill_mask    <= '0;
                ptr          <= '0;
                state        <= STRIPE_EMPTY;
            end
        end
    end

    assign bus.lane_data      = lane_data_q;
    assign bus.lane_valid     = lane_valid_q;
    assign bus.stripe_partial = partial_q;
    assign bus.lane_ptr       = ptr;

endmodule

// File: tb/tb_striping_nlane.sv
// tb/tb_striping_nlane.sv - self-checking bench for striping_nlane (directed table plus randomized model check)
module tb_striping_nlane;

    localparam int DW   = 32;
    localparam int NL   = 4;
    localparam int GAP  = 2;
`ifdef STRIPING_IDLE_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic clk_2f = 1'b0;
    logic reset  = 1'b1;

    always #5 clk_2f = ~clk_2f;

    striping_nlane_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();

    striping_nlane #(
        .DATA_WIDTH (DW),
        .NUM_LANES  (NL),
        .IDLE_GAP   (GAP)
    ) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of pending words and an idle count.
    logic [DW-1:0]    mq[$];
    int               m_idle = 0;
    logic [NL*DW-1:0] m_data = '0;
    logic [NL-1:0]    m_valid = '0;
    bit               m_partial = 1'b0;

    task automatic model_step(input bit r, input bit v, input logic [DW-1:0] d);
        m_valid   = '0;
        m_partial = 1'b0;
        if (r) begin
            mq.delete();
            m_idle = 0;
            m_data = '0;
        end else if (v) begin
            mq.push_back(d);
            m_idle = 0;
            if (mq.size() == NL) begin
                for (int i = 0; i < NL; i++) m_data[i*DW +: DW] = mq[i];
                m_valid = '1;
                mq.delete();
            end
        end else if (FLUSH_EN && mq.size() > 0) begin
            m_idle++;
            if (m_idle == GAP) begin
                m_data = '0;
                for (int i = 0; i < mq.size(); i++) m_data[i*DW +: DW] = mq[i];
                m_valid   = NL'((1 << mq.size()) - 1);
                m_partial = 1'b1;
                mq.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [NL*DW-1:0] act, input logic [NL*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [DW-1:0] d);
        reset        = r;
        bus.valid_in = v;
        bus.data_in  = d;
        @(posedge clk_2f);
        model_step(r, v, d);
        @(negedge clk_2f);
    endtask

    task automatic check_all(input string tag, input logic [NL-1:0] ev, input bit ep,
                             input logic [1:0] eptr, input logic [NL*DW-1:0] ed);
        check({tag, ".lane_valid"}, NL*DW'(bus.lane_valid), NL*DW'(ev));
        check({tag, ".stripe_partial"}, NL*DW'(bus.stripe_partial), NL*DW'(ep));
        check({tag, ".lane_ptr"}, NL*DW'(bus.lane_ptr), NL*DW'(eptr));
        check({tag, ".lane_data"}, bus.lane_data, ed);
    endtask

    typedef struct {
        bit               rst;
        bit               vld;
        logic [DW-1:0]    data;
        logic [NL-1:0]    ev;
        bit               ep;
        logic [1:0]       eptr;
        logic [NL*DW-1:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit v, input logic [DW-1:0] d, input logic [NL-1:0] ev,
                       input bit ep, input logic [1:0] eptr, input logic [NL*DW-1:0] ed);
        vec_t x;
        x.rst = r; x.vld = v; x.data = d; x.ev = ev; x.ep = ep; x.eptr = eptr; x.ed = ed;
        vecs.push_back(x);
    endtask

    initial begin
        logic [NL*DW-1:0] s_full, s_a, s_b, s_gap, s_rst;
        s_full = {32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};
        s_a    = {32'd4, 32'd3, 32'd2, 32'd1};
        s_b    = {32'd8, 32'd7, 32'd6, 32'd5};
        s_gap  = {32'd5, 32'hAAAAAAAA, 32'd4, 32'd3};
        s_rst  = {32'd8, 32'd7, 32'd6, 32'd5};

        bus.valid_in = 1'b0;
        bus.data_in  = '0;

        // reset state
        add(1, 0, 32'h0,        4'h0, 0, 0, '0);
        add(1, 1, 32'h12345678, 4'h0, 0, 0, '0);
        // full stripe
        add(0, 1, 32'hFFFFFFFF, 4'h0, 0, 1, '0);
        add(0, 1, 32'hEEEEEEEE, 4'h0, 0, 2, '0);
        add(0, 1, 32'hDDDDDDDD, 4'h0, 0, 3, '0);
        add(0, 1, 32'hCCCCCCCC, 4'hF, 0, 0, s_full);
        // back-to-back stripes
        add(0, 1, 32'd1, 4'h0, 0, 1, s_full);
        add(0, 1, 32'd2, 4'h0, 0, 2, s_full);
        add(0, 1, 32'd3, 4'h0, 0, 3, s_full);
        add(0, 1, 32'd4, 4'hF, 0, 0, s_a);
        add(0, 1, 32'd5, 4'h0, 0, 1, s_a);
        add(0, 1, 32'd6, 4'h0, 0, 2, s_a);
        add(0, 1, 32'd7, 4'h0, 0, 3, s_a);
        add(0, 1, 32'd8, 4'hF, 0, 0, s_b);
        // gap shorter than IDLE_GAP, data_in ignored while idle
        add(0, 1, 32'd3,        4'h0, 0, 1, s_b);
        add(0, 1, 32'd4,        4'h0, 0, 2, s_b);
        add(0, 0, 32'hDEADBEEF, 4'h0, 0, 2, s_b);
        add(0, 1, 32'hAAAAAAAA, 4'h0, 0, 3, s_b);
        add(0, 1, 32'd5,        4'hF, 0, 0, s_gap);
        // reset mid-stripe
        add(0, 1, 32'hAAAAAAAA, 4'h0, 0, 1, s_gap);
        add(0, 1, 32'hAAAAAAAA, 4'h0, 0, 2, s_gap);
        add(1, 0, 32'h0,        4'h0, 0, 0, '0);
        add(0, 1, 32'd5, 4'h0, 0, 1, '0);
        add(0, 1, 32'd6, 4'h0, 0, 2, '0);
        add(0, 1, 32'd7, 4'h0, 0, 3, '0);
        add(0, 1, 32'd8, 4'hF, 0, 0, s_rst);

        foreach (vecs[k]) begin
            cycle(vecs[k].rst, vecs[k].vld, vecs[k].data);
            check_all($sformatf("vec%0d", k), vecs[k].ev, vecs[k].ep, vecs[k].eptr, vecs[k].ed);
        end

`ifdef STRIPING_IDLE_FLUSH_EN
        // single-word flush after two idle cycles
        cycle(0, 1, 32'h00000200); check_all("flush1.acc", 4'h0, 0, 1, s_rst);
        cycle(0, 0, 32'h0);        check_all("flush1.idle1", 4'h0, 0, 1, s_rst);
        cycle(0, 0, 32'h0);        check_all("flush1.emit", 4'h1, 1, 0, {96'h0, 32'h00000200});
        cycle(0, 0, 32'h0);        check_all("flush1.after", 4'h0, 0, 0, {96'h0, 32'h00000200});
        // idle count restarted by a word on count 1, then two-word flush
        cycle(0, 1, 32'h11); check_all("flush2.w0", 4'h0, 0, 1, {96'h0, 32'h00000200});
        cycle(0, 0, 32'h0);  check_all("flush2.i0", 4'h0, 0, 1, {96'h0, 32'h00000200});
        cycle(0, 1, 32'h22); check_all("flush2.w1", 4'h0, 0, 2, {96'h0, 32'h00000200});
        cycle(0, 0, 32'h0);  check_all("flush2.i1", 4'h0, 0, 2, {96'h0, 32'h00000200});
        cycle(0, 0, 32'h0);  check_all("flush2.emit", 4'h3, 1, 0, {64'h0, 32'h22, 32'h11});
`else
        // long gap is transparent without the flush path
        cycle(0, 1, 32'd1); check_all("nofl.w1", 4'h0, 0, 1, s_rst);
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 32'h0);
            check_all($sformatf("nofl.idle%0d", k), 4'h0, 0, 1, s_rst);
        end
        cycle(0, 1, 32'd2); check_all("nofl.w2", 4'h0, 0, 2, s_rst);
        cycle(0, 1, 32'd3); check_all("nofl.w3", 4'h0, 0, 3, s_rst);
        cycle(0, 1, 32'd4); check_all("nofl.w4", 4'hF, 0, 0, s_a);
`endif

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            bit r, v;
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 9) < 6);
            cycle(r, v, $urandom);
            check_all($sformatf("rand%0d", k), m_valid, m_partial, 2'(mq.size()), m_data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
